// File: rtl/bandai_mapper_gen2.sv
// -----------------------------------------------------------------------------
// bandai_mapper_gen2
// Cartridge mapper between the console bus and the ROM/RAM chips.
//  - NUM_BANKS bank registers at REG_BASE..REG_BASE+NUM_BANKS-1.
//  - Bank writes are only accepted once the serial unlock stream has been
//    played out on SO after the bus presented UNLOCK_ADDR.
//  - WEn is synchronised into CLK and edge-detected; it is never a clock.
//  - Chip enables and high address bits RADDR are combinational.
// Build option:
//  - BANK_RDBK_EN : when defined, bank registers can be read back on DQ.
//                   When undefined, registers are write-only and DQ is Z.
// -----------------------------------------------------------------------------
module bandai_mapper_gen2 #(
  parameter int unsigned            NUM_BANKS   = 4,
  parameter int unsigned            BANK_W      = 8,
  parameter int unsigned            RADDR_W     = 7,
  parameter logic [7:0]             REG_BASE    = 8'hC0,
  parameter logic [7:0]             UNLOCK_ADDR = 8'hA5,
  parameter int unsigned            UNLOCK_LEN  = 18,
  parameter logic [UNLOCK_LEN-1:0]  UNLOCK_PAT  = 18'h05140
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               CEn,
  input  logic               SSn,
  input  logic               WEn,
  input  logic               OEn,
  input  logic [7:0]         ADDR,
  inout  wire  [7:0]         DQ,
  output wire                SO,
  output logic               ROMCEn,
  output logic               RAMCEn,
  output logic [RADDR_W-1:0] RADDR
);

  localparam int unsigned IDX_W  = $clog2(NUM_BANKS);
  localparam int unsigned CNT_W  = $clog2(UNLOCK_LEN);
  localparam logic [3:0]  NB_SEG = 4'(NUM_BANKS);

  typedef enum logic [1:0] {
    ST_LOCKED,
    ST_SHIFT,
    ST_UNLOCKED
  } state_e;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [3:0]       seg;
  logic [IDX_W-1:0] reg_idx;
  logic             regsel;
  logic             rce;
  logic             ram_sel;
  logic             rom_sel;

  assign seg     = ADDR[7:4];
  assign reg_idx = ADDR[IDX_W-1:0];
  // REG_BASE is NUM_BANKS-aligned, so matching the upper bits covers the range.
  assign regsel  = ~(SSn & CEn) && (ADDR[7:IDX_W] == REG_BASE[7:IDX_W]);
  assign rce     = SSn & ~CEn;
  assign ram_sel = rce && (seg == 4'd1);
  assign rom_sel = rce && (seg > 4'd1);

  // ---------------------------------------------------------------------------
  // Unlock FSM and serial stream
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [UNLOCK_LEN-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic                  so_bit;

  // State register for the unlock sequencer.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_LOCKED;
      shreg_q <= '1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: start on UNLOCK_ADDR, play the pattern LSB first, park.
  // NOTE: every output of this block is defaulted first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    so_bit  = 1'b1;
    unique case (state_q)
      ST_LOCKED: begin
        if (ADDR == UNLOCK_ADDR) begin
          state_d = ST_SHIFT;
          shreg_d = UNLOCK_PAT;
          cnt_d   = CNT_W'(UNLOCK_LEN - 1);
        end
      end
      ST_SHIFT: begin
        so_bit  = shreg_q[0];
        shreg_d = {1'b1, shreg_q[UNLOCK_LEN-1:1]};
        if (cnt_q == '0) begin
          state_d = ST_UNLOCKED;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_UNLOCKED: begin
        // Terminal; a repeated UNLOCK_ADDR has no effect.
      end
      default: state_d = ST_LOCKED;
    endcase
  end

  // SO floats while the mapper is held in reset.
  assign SO = RSTn ? so_bit : 1'bz;

  // ---------------------------------------------------------------------------
  // Write capture: WEn synchroniser, rise detect, address/data latch
  // ---------------------------------------------------------------------------
  logic              we_s1_q, we_s2_q, we_prev_q;
  logic              we_rise;
  logic              lat_valid_q;
  logic [IDX_W-1:0]  lat_idx_q;
  logic [BANK_W-1:0] lat_data_q;
  logic              commit;

  // Two-flop synchroniser plus one delay stage for edge detection.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      we_s1_q   <= 1'b1;
      we_s2_q   <= 1'b1;
      we_prev_q <= 1'b1;
    end else begin
      we_s1_q   <= WEn;
      we_s2_q   <= we_s1_q;
      we_prev_q <= we_s2_q;
    end
  end

  assign we_rise = we_s2_q & ~we_prev_q;

  // Hold the last register address/data seen while the write strobe is low;
  // the rise ends the write, whether it commits or is dropped.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      lat_valid_q <= 1'b0;
      lat_idx_q   <= '0;
      lat_data_q  <= '0;
    end else if (we_rise) begin
      lat_valid_q <= 1'b0;
    end else if (!we_s2_q && regsel) begin
      lat_valid_q <= 1'b1;
      lat_idx_q   <= reg_idx;
      lat_data_q  <= DQ[BANK_W-1:0];
    end
  end

  assign commit = we_rise && lat_valid_q && (state_q == ST_UNLOCKED);

  // ---------------------------------------------------------------------------
  // Bank registers
  // ---------------------------------------------------------------------------
  logic [BANK_W-1:0] bank_q [NUM_BANKS];

  // Bank update on commit.
  // NOTE: this small register array is reset explicitly because its all-ones
  // power-up value is architectural; large RAM-style arrays normally are not.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int k = 0; k < NUM_BANKS; k++) begin
        bank_q[k] <= '1;
      end
    end else if (commit) begin
      bank_q[lat_idx_q] <= lat_data_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Chip enables and high address bits
  // ---------------------------------------------------------------------------
  // Banked segments take their bank; upper segments form a linear window.
  always_comb begin
    RAMCEn = ~ram_sel;
    ROMCEn = ~rom_sel;
    RADDR  = '0;
    if (ram_sel || rom_sel) begin
      if (seg < NB_SEG) begin
        RADDR = bank_q[seg[IDX_W-1:0]][RADDR_W-1:0];
      end else begin
        RADDR = {bank_q[0][RADDR_W-5:0], seg};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data bus
  // ---------------------------------------------------------------------------
`ifdef BANK_RDBK_EN
  logic [7:0] rd_data;

  // Zero-extend the selected bank onto the 8-bit bus.
  always_comb begin
    rd_data                = '0;
    rd_data[BANK_W-1:0]    = bank_q[reg_idx];
  end

  assign DQ = (regsel && !OEn && WEn) ? rd_data : 8'hzz;
`else
  assign DQ = 8'hzz;
`endif

  // Sink for bank bits and strobes that only some builds consume.
  logic unused_sink;
  always_comb begin
    unused_sink = OEn;
    for (int k = 0; k < NUM_BANKS; k++) begin
      unused_sink = unused_sink ^ (^bank_q[k]);
    end
  end

endmodule

// File: tb/tb_bandai_mapper_gen2.sv
// -----------------------------------------------------------------------------
// tb_bandai_mapper_gen2
// Directed scenarios plus randomized bus traffic, checked every cycle against a
// transaction-level model of the mapper. Build with +define+BANK_RDBK_EN to
// exercise register readback.
// -----------------------------------------------------------------------------
module tb_bandai_mapper_gen2;

  localparam int          NB  = 4;
  localparam logic [17:0] PAT = 18'h05140;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b1;
  logic       CEn, SSn, WEn, OEn;
  logic [7:0] ADDR;
  wire  [7:0] DQ;
  wire        SO;
  wire        ROMCEn, RAMCEn;
  wire  [6:0] RADDR;

  logic [7:0] dq_val;
  logic       dq_oe;
  logic       cmp_en;

  // Undriven bus lines settle low, which makes a floating output observable.
  assign DQ = dq_oe ? dq_val : 8'hzz;
  pulldown (DQ);
  pulldown (SO);

  bandai_mapper_gen2 dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .CEn    (CEn),
    .SSn    (SSn),
    .WEn    (WEn),
    .OEn    (OEn),
    .ADDR   (ADDR),
    .DQ     (DQ),
    .SO     (SO),
    .ROMCEn (ROMCEn),
    .RAMCEn (RAMCEn),
    .RADDR  (RADDR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: banks, unlock start edge, pending commits keyed by edge
  // ---------------------------------------------------------------------------
  typedef struct {
    int         e;
    int         i;
    logic [7:0] d;
  } cm_t;

  logic [7:0] bank_m [NB];
  bit         started;
  int         u_edge;
  int         edge_cnt;
  bit         prev_wen;
  bit         lat_v;
  int         lat_i;
  logic [7:0] lat_d;
  cm_t        cq [$];

  function automatic void model_reset();
    foreach (bank_m[k]) bank_m[k] = 8'hFF;
    started  = 1'b0;
    u_edge   = 0;
    edge_cnt = 0;
    prev_wen = 1'b1;
    lat_v    = 1'b0;
    cq.delete();
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RSTn);
      if (!RSTn) begin
        model_reset();
      end else begin
        bit  unl;
        cm_t c;
        edge_cnt++;
        // Unlocked means the full 18-bit stream finished before this edge.
        unl = started && ((edge_cnt - 1 - u_edge) >= 18);
        for (int k = cq.size() - 1; k >= 0; k--) begin
          if (cq[k].e == edge_cnt) begin
            if (unl) bank_m[cq[k].i] = cq[k].d;
            cq.delete(k);
          end
        end
        if (!started && ADDR == 8'hA5) begin
          started = 1'b1;
          u_edge  = edge_cnt;
        end
        if (!WEn && !(SSn && CEn) && ADDR >= 8'hC0 && ADDR <= 8'hC3) begin
          lat_v = 1'b1;
          lat_i = ADDR - 8'hC0;
          lat_d = DQ;
        end
        // A write ends at the WEn rise; it lands two edges after the first
        // edge that sees WEn high.
        if (WEn && !prev_wen) begin
          if (lat_v) begin
            c.e = edge_cnt + 2;
            c.i = lat_i;
            c.d = lat_d;
            cq.push_back(c);
          end
          lat_v = 1'b0;
        end
        prev_wen = WEn;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle comparison against the model
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge CLK);
      if (cmp_en) begin
        int   seg;
        bit   rce;
        int   raddr_e;
        bit   so_e;
        int   j;
        logic [7:0] dq_e;
        seg = int'(ADDR) / 16;
        rce = SSn && !CEn;
        if (!rce || seg == 0)  raddr_e = 0;
        else if (seg < NB)     raddr_e = int'(bank_m[seg]) % 128;
        else                   raddr_e = (int'(bank_m[0]) * 16 + seg) % 128;
        if (!RSTn)             so_e = 1'b0;
        else if (!started)     so_e = 1'b1;
        else begin
          j    = edge_cnt - u_edge;
          so_e = (j < 18) ? PAT[j] : 1'b1;
        end
        check("ramcen", RAMCEn, !(rce && seg == 1));
        check("romcen", ROMCEn, !(rce && seg > 1));
        check("raddr",  RADDR,  raddr_e);
        check("so",     SO,     so_e);
        if (!dq_oe) begin
          dq_e = 8'h00;
`ifdef BANK_RDBK_EN
          if (!(SSn && CEn) && ADDR >= 8'hC0 && ADDR <= 8'hC3 && !OEn && WEn)
            dq_e = bank_m[ADDR - 8'hC0];
`endif
          check("dq", DQ, dq_e);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Register write; returns just before the commit edge with the bus on view_a.
  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic [7:0] view_a,
                    input logic ss, input logic ce);
    ADDR   = a;
    SSn    = ss;
    CEn    = ce;
    OEn    = 1'b1;
    dq_val = d;
    dq_oe  = 1'b1;
    WEn    = 1'b0;
    step();
    step();
    WEn = 1'b1;
    step();
    step();
    ADDR  = view_a;
    SSn   = 1'b1;
    CEn   = 1'b0;
    dq_oe = 1'b0;
  endtask

  int so_ref [18] = '{0,0,0,0,0,0,1,0,1,0,0,0,1,0,1,0,0,0};
  int so_seen [18];

  initial begin
    CEn = 1'b1; SSn = 1'b1; WEn = 1'b1; OEn = 1'b1;
    ADDR = 8'h00; dq_val = 8'h00; dq_oe = 1'b0; cmp_en = 1'b0;

    // Reset: SO floats (reads low through the pull).
    #2 RSTn = 1'b0;
    cmp_en = 1'b1;
    @(negedge CLK);
    check("so_in_reset", SO, 1'b0);
    step();
    RSTn = 1'b1; ADDR = 8'h20; SSn = 1'b1; CEn = 1'b0;
    @(negedge CLK);
    check("rst_so",     SO,     1'b1);
    check("rst_raddr",  RADDR,  7'h7F);
    check("rst_romcen", ROMCEn, 1'b0);
    check("rst_ramcen", RAMCEn, 1'b1);

    // Write while locked is dropped.
    wr(8'hC2, 8'h12, 8'h20, 1'b1, 1'b0);
    step();
    step();
    @(negedge CLK);
    check("locked_wr_dropped", RADDR, 7'h7F);

    // Unlock stream, with a second UNLOCK_ADDR mid-stream.
    step();
    ADDR = 8'hA5;
    step();
    ADDR = 8'h20;
    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      so_seen[i] = SO;
      step();
      if (i == 4) ADDR = 8'hA5;
      if (i == 5) ADDR = 8'h20;
    end
    for (int i = 0; i < 18; i++) check($sformatf("so_bit%0d", i), so_seen[i], so_ref[i]);
    ADDR = 8'hA5;
    step();
    ADDR = 8'h20;
    repeat (3) begin
      @(negedge CLK);
      check("so_steady", SO, 1'b1);
    end

    // Unlocked write lands on the third edge after the WEn rise.
    wr(8'hC2, 8'h12, 8'h20, 1'b1, 1'b0);
    @(negedge CLK);
    check("commit_not_early", RADDR, 7'h7F);
    step();
    @(negedge CLK);
    check("bank2_raddr",  RADDR,  7'h12);
    check("bank2_romcen", ROMCEn, 1'b0);
    check("bank2_ramcen", RAMCEn, 1'b1);

    wr(8'hC0, 8'h03, 8'h50, 1'b0, 1'b0);
    step();
    @(negedge CLK);
    check("linear_raddr", RADDR, 7'h35);

    wr(8'hC1, 8'h07, 8'h10, 1'b1, 1'b0);
    step();
    @(negedge CLK);
    check("ram_ramcen", RAMCEn, 1'b0);
    check("ram_raddr",  RADDR,  7'h07);
    step();
    CEn = 1'b1;
    @(negedge CLK);
    check("idle_ramcen", RAMCEn, 1'b1);
    check("idle_romcen", ROMCEn, 1'b1);
    check("idle_raddr",  RADDR,  7'h00);

    // Register read on the data bus.
    step();
    ADDR = 8'hC1; CEn = 1'b0; SSn = 1'b1; OEn = 1'b0;
    @(negedge CLK);
`ifdef BANK_RDBK_EN
    check("readback_bank1", DQ, 8'h07);
`else
    check("dq_float", DQ, 8'h00);
`endif
    step();
    OEn = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      int r;
      int sel;
      r   = $urandom_range(0, 3);
      sel = $urandom_range(0, 2);
      if (r == 0) begin
        wr(8'hC0 + 8'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
           (sel == 0) ? 1'b0 : 1'b1, (sel == 1) ? 1'b1 : 1'b0);
        step();
      end else begin
        repeat ($urandom_range(1, 3)) begin
          ADDR = ($urandom_range(0, 1) == 0) ? 8'hC0 + 8'($urandom_range(0, 3)) : 8'($urandom);
          SSn  = 1'($urandom);
          CEn  = 1'($urandom);
          OEn  = 1'($urandom);
          step();
        end
      end
    end

    // Reset in the middle of the unlock stream.
    OEn = 1'b1; SSn = 1'b1; CEn = 1'b0;
    step();
    check("pre_reset_raddr_not_ff", (RADDR != 7'h7F) || (bank_m[2] == 8'hFF), 1'b1);
    step();
    RSTn = 1'b1;
    ADDR = 8'h00;
    step();
    // Reset then unlock partially.
    #2 RSTn = 1'b0;
    step();
    RSTn = 1'b1;
    ADDR = 8'hA5;
    step();
    ADDR = 8'h20;
    repeat (5) step();
    #2 RSTn = 1'b0;
    @(negedge CLK);
    check("midshift_so_float", SO,    1'b0);
    check("midshift_banks_ff", RADDR, 7'h7F);
    step();
    RSTn = 1'b1;
    wr(8'hC2, 8'h55, 8'h20, 1'b1, 1'b0);
    step();
    step();
    @(negedge CLK);
    check("relocked_wr_dropped", RADDR, 7'h7F);

    // Fresh unlock after reset, then a write that must land.
    ADDR = 8'hA5;
    step();
    ADDR = 8'h20;
    repeat (22) step();
    wr(8'hC3, 8'h5A, 8'h30, 1'b1, 1'b0);
    step();
    @(negedge CLK);
    check("relock_then_unlock_wr", RADDR, 7'h5A);

    step();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
